// File: rtl/branch_pkg.sv
// Shared types and constants for the branch control unit: PC mux select
// encoding and the fetch-stage op class that marks a branch or jump.
package branch_pkg;

  typedef enum logic [1:0] {
    PC_SRC_PLUS4_F  = 2'b00,
    PC_SRC_PRED_TGT = 2'b01,
    PC_SRC_PLUS4_E  = 2'b10,
    PC_SRC_TGT_E    = 2'b11
  } pc_src_t;

  localparam logic [1:0] OP_BRANCH_CLASS = 2'b11;

  // The rollback selects are the only encodings with the MSB set.
  function automatic logic isRollback(input pc_src_t src);
    return src[1];
  endfunction

endpackage

// File: rtl/branch_perf_counter.sv
// Single saturating event counter with asynchronous active-low clear.
module branch_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Hold at all-ones instead of wrapping back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_control_unit.sv
// Next-PC source selection: fetch-stage prediction, overridden by an
// execute-stage rollback on misprediction, plus branch/mispredict counters.
module branch_control_unit
  import branch_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [1:0]       op_f_i,
  input  logic             pc_src_pred_f_i,
  input  logic             pc_src_pred_e_i,
  input  logic [1:0]       branch_op_e_i,
  input  logic             target_match_e_i,
  input  logic             pc_src_res_e_i,
  output logic [1:0]       pc_src_o,
  output logic             mispredict_e_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  pc_src_t predSrc;
  pc_src_t pcSrc;
  logic    resolveValid;
  logic    unusedBranchOpHi;

  assign resolveValid     = branch_op_e_i[0];
  assign unusedBranchOpHi = branch_op_e_i[1];

  always_comb begin
    predSrc = PC_SRC_PLUS4_F;
    if ((op_f_i == OP_BRANCH_CLASS) && pc_src_pred_f_i) begin
      predSrc = PC_SRC_PRED_TGT;
    end
  end

  // A taken-with-right-target or not-taken-as-predicted outcome keeps the
  // fetch-stage choice; anything else rolls back from the E stage.
  always_comb begin
    pcSrc = predSrc;
    if (resolveValid) begin
      if (pc_src_pred_e_i && !pc_src_res_e_i) begin
        pcSrc = PC_SRC_PLUS4_E;
      end else if (pc_src_res_e_i && (!pc_src_pred_e_i || !target_match_e_i)) begin
        pcSrc = PC_SRC_TGT_E;
      end
    end
  end

  assign pc_src_o       = pcSrc;
  assign mispredict_e_o = isRollback(pcSrc);

  branch_perf_counter #(.CNT_W(CNT_W)) u_branchCnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (resolveValid),
    .cnt_o   (branch_cnt_o)
  );

  branch_perf_counter #(.CNT_W(CNT_W)) u_mispredictCnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (mispredict_e_o),
    .cnt_o   (mispredict_cnt_o)
  );

endmodule

// File: tb/tb_branch_control_unit.sv
// Directed-vector bench for branch_control_unit: table of combinational
// select cases plus hand-written counter, reset and saturation sequences.
module tb_branch_control_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  opF;
  logic        predF;
  logic        predE;
  logic [1:0]  branchOpE;
  logic        targetMatchE;
  logic        resE;
  logic [1:0]  pcSrc;
  logic        mispredict;
  logic [31:0] branchCnt;
  logic [31:0] mispredictCnt;
  logic [1:0]  pcSrcSmall;
  logic        mispredictSmall;
  logic [3:0]  branchCntSmall;
  logic [3:0]  mispredictCntSmall;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [1:0] opF;
    logic       predF;
    logic [1:0] branchOp;
    logic       tm;
    logic       pe;
    logic       re;
    logic [1:0] expPcSrc;
  } vec_t;

  vec_t vecs[$];

  branch_control_unit dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .op_f_i           (opF),
    .pc_src_pred_f_i  (predF),
    .pc_src_pred_e_i  (predE),
    .branch_op_e_i    (branchOpE),
    .target_match_e_i (targetMatchE),
    .pc_src_res_e_i   (resE),
    .pc_src_o         (pcSrc),
    .mispredict_e_o   (mispredict),
    .branch_cnt_o     (branchCnt),
    .mispredict_cnt_o (mispredictCnt)
  );

  branch_control_unit #(.CNT_W(4)) dutSmall (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .op_f_i           (opF),
    .pc_src_pred_f_i  (predF),
    .pc_src_pred_e_i  (predE),
    .branch_op_e_i    (branchOpE),
    .target_match_e_i (targetMatchE),
    .pc_src_res_e_i   (resE),
    .pc_src_o         (pcSrcSmall),
    .mispredict_e_o   (mispredictSmall),
    .branch_cnt_o     (branchCntSmall),
    .mispredict_cnt_o (mispredictCntSmall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] o, input logic pf, input logic [1:0] bo,
                              input logic [2:0] tpr, input logic [1:0] exp);
    vec_t v;
    v.opF = o; v.predF = pf; v.branchOp = bo;
    v.tm = tpr[2]; v.pe = tpr[1]; v.re = tpr[0];
    v.expPcSrc = exp;
    return v;
  endfunction

  task automatic applyStimulus(input logic [1:0] o, input logic pf, input logic [1:0] bo,
                               input logic tm, input logic pe, input logic re);
    opF = o; predF = pf; branchOpE = bo;
    targetMatchE = tm; predE = pe; resE = re;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Non-branching fetch ops never predict, whatever the predictor says.
    vecs.push_back(mk(2'd0, 1'b1, 2'b00, 3'b000, 2'b00));
    vecs.push_back(mk(2'd1, 1'b0, 2'b00, 3'b000, 2'b00));
    vecs.push_back(mk(2'd2, 1'b1, 2'b00, 3'b000, 2'b00));
    vecs.push_back(mk(2'd0, 1'b0, 2'b00, 3'b000, 2'b00));
    vecs.push_back(mk(2'd1, 1'b1, 2'b00, 3'b000, 2'b00));
    vecs.push_back(mk(2'd2, 1'b0, 2'b00, 3'b000, 2'b00));
    vecs.push_back(mk(2'd3, 1'b1, 2'b00, 3'b000, 2'b01));
    vecs.push_back(mk(2'd3, 1'b0, 2'b00, 3'b000, 2'b00));
    // Resolution sweep {tm,pe,re}, predF=0
    vecs.push_back(mk(2'd3, 1'b0, 2'b01, 3'b111, 2'b00));
    vecs.push_back(mk(2'd3, 1'b0, 2'b01, 3'b011, 2'b11));
    vecs.push_back(mk(2'd3, 1'b0, 2'b01, 3'b010, 2'b10));
    vecs.push_back(mk(2'd3, 1'b0, 2'b01, 3'b110, 2'b10));
    vecs.push_back(mk(2'd3, 1'b0, 2'b01, 3'b101, 2'b11));
    vecs.push_back(mk(2'd3, 1'b0, 2'b01, 3'b001, 2'b11));
    vecs.push_back(mk(2'd3, 1'b0, 2'b01, 3'b000, 2'b00));
    vecs.push_back(mk(2'd3, 1'b0, 2'b01, 3'b100, 2'b00));
    // Same sweep, predF=1
    vecs.push_back(mk(2'd3, 1'b1, 2'b01, 3'b111, 2'b01));
    vecs.push_back(mk(2'd3, 1'b1, 2'b01, 3'b011, 2'b11));
    vecs.push_back(mk(2'd3, 1'b1, 2'b01, 3'b010, 2'b10));
    vecs.push_back(mk(2'd3, 1'b1, 2'b01, 3'b110, 2'b10));
    vecs.push_back(mk(2'd3, 1'b1, 2'b01, 3'b101, 2'b11));
    vecs.push_back(mk(2'd3, 1'b1, 2'b01, 3'b001, 2'b11));
    vecs.push_back(mk(2'd3, 1'b1, 2'b01, 3'b000, 2'b01));
    vecs.push_back(mk(2'd3, 1'b1, 2'b01, 3'b100, 2'b01));
    // No resolution: E inputs ignored
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(2'd3, 1'b0, 2'b00, 3'(i), 2'b00));
    end
    vecs.push_back(mk(2'd3, 1'b1, 2'b10, 3'b010, 2'b01));
    vecs.push_back(mk(2'd0, 1'b1, 2'b11, 3'b010, 2'b10));
    vecs.push_back(mk(2'd1, 1'b0, 2'b01, 3'b001, 2'b11));

    rst_n = 1'b0;
    applyStimulus(2'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    #12;
    checkOutput("reset_branch_cnt", branchCnt, 32'd0);
    checkOutput("reset_mispredict_cnt", mispredictCnt, 32'd0);

    // Combinational table, applied while reset is held.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].opF, vecs[i].predF, vecs[i].branchOp,
                    vecs[i].tm, vecs[i].pe, vecs[i].re);
      #1;
      checkOutput($sformatf("pc_src_vec%0d", i), 32'(pcSrc), 32'(vecs[i].expPcSrc));
      checkOutput($sformatf("mispredict_vec%0d", i), 32'(mispredict), 32'(vecs[i].expPcSrc[1]));
    end

    @(negedge clk);
    applyStimulus(2'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    runCycles(2);
    checkOutput("idle_branch_cnt", branchCnt, 32'd0);

    // 3 correct predictions, 2 rollbacks, then 2 stall cycles.
    applyStimulus(2'd3, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1);
    runCycles(3);
    checkOutput("correct_branch_cnt", branchCnt, 32'd3);
    checkOutput("correct_mispredict_cnt", mispredictCnt, 32'd0);
    applyStimulus(2'd3, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0);
    runCycles(2);
    applyStimulus(2'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    runCycles(2);
    checkOutput("seq_branch_cnt", branchCnt, 32'd5);
    checkOutput("seq_mispredict_cnt", mispredictCnt, 32'd2);
    checkOutput("seq_branch_cnt_small", 32'(branchCntSmall), 32'd5);
    checkOutput("seq_mispredict_cnt_small", 32'(mispredictCntSmall), 32'd2);

    // Mid-cycle asynchronous reset clears without a clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_branch_cnt", branchCnt, 32'd0);
    checkOutput("async_mispredict_cnt", mispredictCnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 20 rollback cycles: 4-bit counters saturate, 32-bit reach 20.
    applyStimulus(2'd3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    runCycles(20);
    checkOutput("sat_branch_cnt_small", 32'(branchCntSmall), 32'hF);
    checkOutput("sat_mispredict_cnt_small", 32'(mispredictCntSmall), 32'hF);
    checkOutput("wide_branch_cnt", branchCnt, 32'd20);
    checkOutput("wide_mispredict_cnt", mispredictCnt, 32'd20);
    checkOutput("sat_pc_src_small", 32'(pcSrcSmall), 32'd3);
    checkOutput("sat_mispredict_small", 32'(mispredictSmall), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
